// File: rtl/heartbeat_pkg.sv
// Shared types and constants for the multi-channel heartbeat monitor.
package heartbeat_pkg;

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_IDLE  = 2'd1,
    ST_MON   = 2'd2,
    ST_FAULT = 2'd3
  } ch_state_e;

  localparam int CAUSE_TIMEOUT = 0;
  localparam int CAUSE_FAST    = 1;

  localparam int EVT_W = 16;

endpackage

// File: rtl/heartbeat_channel.sv
// One heartbeat channel: input synchroniser, edge detector, gap counter and
// the BLANK/IDLE/MON/FAULT state machine.
module heartbeat_channel
  import heartbeat_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int TIMEOUT_CYC  = 45000,
  parameter int MIN_EDGE_CYC = 0,
  parameter int SYNC_STAGES  = 2,
  parameter int LATCH_FAULT  = 1
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iHeartbeat,
  input  logic       iChEn,
  input  logic       iClear,
  input  logic       iReady,
  output logic       oFault,
  output logic [1:0] oCause,
  output logic       oNewFault
);

  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST_V    = CNT_W'(TIMEOUT_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   strobe;
  logic                   too_fast;

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       cause_q, cause_d;
  logic             new_fault;

  // NOTE: every flop uses non-blocking assignment so all state updates on the
  // same edge see the pre-edge values of each other.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], iHeartbeat};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Either polarity of the synchronised heartbeat counts as an edge.
  assign strobe  = sync_q[SYNC_STAGES-1] ^ prev_q;
  assign cnt_inc = (cnt_q == TIMEOUT_V) ? cnt_q : cnt_q + CNT_W'(1);

  generate
    if (MIN_EDGE_CYC > 0) begin : g_fast
      localparam logic [CNT_W-1:0] MIN_V = CNT_W'(MIN_EDGE_CYC);
      assign too_fast = strobe && (cnt_q < MIN_V);
    end else begin : g_no_fast
      assign too_fast = 1'b0;
    end
  endgenerate

  // NOTE: every output of this block gets a default first, so no branch can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cause_d   = cause_q;
    new_fault = 1'b0;

    unique case (state_q)
      ST_BLANK: begin
        cnt_d = '0;
        if (iReady) state_d = iChEn ? ST_MON : ST_IDLE;
      end

      ST_IDLE: begin
        cnt_d   = '0;
        cause_d = '0;
        if (iChEn) state_d = ST_MON;
      end

      ST_MON: begin
        if (!iChEn) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (too_fast || (!strobe && cnt_q == LAST_V)) begin
          // A clear coinciding with a new fault condition wins.
          if (iClear) begin
            cnt_d = '0;
          end else begin
            state_d                = ST_FAULT;
            cnt_d                  = strobe ? '0 : cnt_inc;
            cause_d                = '0;
            cause_d[CAUSE_FAST]    = too_fast;
            cause_d[CAUSE_TIMEOUT] = !too_fast;
            new_fault              = 1'b1;
          end
        end else begin
          cnt_d = strobe ? '0 : cnt_inc;
        end
      end

      ST_FAULT: begin
        cnt_d = strobe ? '0 : cnt_inc;
        if (!iChEn) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          cause_d = '0;
        end else if (iClear) begin
          state_d = ST_MON;
          cnt_d   = '0;
          cause_d = '0;
        end else if (LATCH_FAULT == 0) begin
          if (too_fast) begin
            cause_d             = '0;
            cause_d[CAUSE_FAST] = 1'b1;
          end else if (strobe) begin
            state_d = ST_MON;
            cnt_d   = '0;
            cause_d = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  assign oFault    = (state_q == ST_FAULT);
  assign oCause    = cause_q;
  assign oNewFault = new_fault;

endmodule

// File: rtl/heartbeat_monitor.sv
// Multi-channel heartbeat watchdog: shared startup blanking, per-channel
// monitors and a saturating count of fault-entry events.
module heartbeat_monitor
  import heartbeat_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int CNT_W        = 32,
  parameter int TIMEOUT_CYC  = 45000,
  parameter int MIN_EDGE_CYC = 0,
  parameter int START_CYC    = 30000,
  parameter int SYNC_STAGES  = 2,
  parameter int LATCH_FAULT  = 1
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic [N_CH-1:0]   iHeartbeat,
  input  logic [N_CH-1:0]   iChEn,
  input  logic [N_CH-1:0]   iClear,
  output logic [N_CH-1:0]   oFault,
  output logic [2*N_CH-1:0] oCause,
  output logic              oAnyFault,
  output logic              oReady,
  output logic [EVT_W-1:0]  oEvtCnt
);

  localparam logic [CNT_W-1:0] START_V = CNT_W'(START_CYC);

  logic [CNT_W-1:0] start_cnt_q, start_cnt_d;
  logic             ready_q, ready_d;
  logic [EVT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic [N_CH-1:0]  new_fault;

  // Ready is registered from the next count so it rises on the edge the
  // blanking counter reaches START_CYC.
  always_comb begin
    start_cnt_d = (start_cnt_q == START_V) ? start_cnt_q : start_cnt_q + CNT_W'(1);
    ready_d     = (start_cnt_d == START_V);
    evt_cnt_d   = evt_cnt_q;
    if ((|new_fault) && (evt_cnt_q != '1)) evt_cnt_d = evt_cnt_q + EVT_W'(1);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      start_cnt_q <= '0;
      ready_q     <= 1'b0;
      evt_cnt_q   <= '0;
    end else begin
      start_cnt_q <= start_cnt_d;
      ready_q     <= ready_d;
      evt_cnt_q   <= evt_cnt_d;
    end
  end

  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
      heartbeat_channel #(
        .CNT_W        (CNT_W),
        .TIMEOUT_CYC  (TIMEOUT_CYC),
        .MIN_EDGE_CYC (MIN_EDGE_CYC),
        .SYNC_STAGES  (SYNC_STAGES),
        .LATCH_FAULT  (LATCH_FAULT)
      ) u_ch (
        .iClk       (iClk),
        .iRst_n     (iRst_n),
        .iHeartbeat (iHeartbeat[g]),
        .iChEn      (iChEn[g]),
        .iClear     (iClear[g]),
        .iReady     (ready_q),
        .oFault     (oFault[g]),
        .oCause     (oCause[2*g +: 2]),
        .oNewFault  (new_fault[g])
      );
    end
  endgenerate

  assign oAnyFault = |oFault;
  assign oReady    = ready_q;
  assign oEvtCnt   = evt_cnt_q;

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Scoreboard bench for heartbeat_monitor: stimulus queues expected output
// values tagged with an absolute cycle, a monitor compares them on negedge.
module tb_heartbeat_monitor;

  logic        iClk = 1'b0;
  logic        iRst_n;
  logic [3:0]  hb, en, clr, hb_sr, en_sr, clr_sr;
  logic [3:0]  fault, fault_sr;
  logic [7:0]  cause, cause_sr;
  logic        any_f, any_sr, ready, ready_sr;
  logic [15:0] evt, evt_sr;

  always #5 iClk = ~iClk;

  heartbeat_monitor #(
    .N_CH(4), .CNT_W(32), .TIMEOUT_CYC(100), .MIN_EDGE_CYC(20),
    .START_CYC(50), .SYNC_STAGES(2), .LATCH_FAULT(1)
  ) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iHeartbeat(hb), .iChEn(en), .iClear(clr),
    .oFault(fault), .oCause(cause), .oAnyFault(any_f), .oReady(ready), .oEvtCnt(evt)
  );

  heartbeat_monitor #(
    .N_CH(4), .CNT_W(32), .TIMEOUT_CYC(100), .MIN_EDGE_CYC(20),
    .START_CYC(50), .SYNC_STAGES(2), .LATCH_FAULT(0)
  ) dut_sr (
    .iClk(iClk), .iRst_n(iRst_n), .iHeartbeat(hb_sr), .iChEn(en_sr), .iClear(clr_sr),
    .oFault(fault_sr), .oCause(cause_sr), .oAnyFault(any_sr), .oReady(ready_sr), .oEvtCnt(evt_sr)
  );

  typedef enum {S_FAULT, S_CAUSE, S_EVT, S_READY, S_ANY, S_SR_FAULT, S_SR_CAUSE, S_SR_EVT} sig_e;
  typedef struct {
    int          at;
    string       name;
    sig_e        sig;
    logic [31:0] mask;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge iClk) cyc <= cyc + 1;

  function automatic logic [31:0] get_sig(sig_e s);
    case (s)
      S_FAULT:    return 32'(fault);
      S_CAUSE:    return 32'(cause);
      S_EVT:      return 32'(evt);
      S_READY:    return 32'(ready);
      S_ANY:      return 32'(any_f);
      S_SR_FAULT: return 32'(fault_sr);
      S_SR_CAUSE: return 32'(cause_sr);
      default:    return 32'(evt_sr);
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 'h%0h, expected 'h%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_exp(int at, string nm, sig_e s, logic [31:0] m, logic [31:0] e);
    exp_t x;
    x.at = at; x.name = nm; x.sig = s; x.mask = m; x.exp = e;
    sb.push_back(x);
  endtask

  // Monitor: compare every queued expectation due on this cycle.
  always @(negedge iClk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        check(sb[i].name, get_sig(sb[i].sig) & sb[i].mask, sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  initial begin
    int r, r2;
    iRst_n = 1'b0;
    hb = '0; en = 4'b0001; clr = '0;
    hb_sr = '0; en_sr = 4'b1000; clr_sr = '0;

    // Reset state
    push_exp(1, "rst_fault", S_FAULT, 'hF,  0);
    push_exp(1, "rst_cause", S_CAUSE, 'hFF, 0);
    push_exp(1, "rst_evt",   S_EVT,   'hFFFF, 0);
    push_exp(2, "rst_ready", S_READY, 1, 0);
    repeat (3) step();
    iRst_n = 1'b1;
    r = cyc;

    // Blanking and first timeout on ch0
    push_exp(r + 49,  "ready_pre",    S_READY, 1, 0);
    push_exp(r + 50,  "ready_rise",   S_READY, 1, 1);
    push_exp(r + 50,  "blank_fault",  S_FAULT, 'hF, 0);
    push_exp(r + 150, "ch0_to_pre",   S_FAULT, 1, 0);
    push_exp(r + 150, "evt_pre",      S_EVT, 'hFFFF, 0);
    push_exp(r + 151, "ch0_to",       S_FAULT, 1, 1);
    push_exp(r + 151, "ch0_to_cause", S_CAUSE, 'h3, 'h1);
    push_exp(r + 151, "evt_1",        S_EVT, 'hFFFF, 1);
    push_exp(r + 151, "any_fault",    S_ANY, 1, 1);
    push_exp(r + 151, "sr_ch3_to",    S_SR_FAULT, 'h8, 'h8);

    // Healthy ch1, then timeout 100 cycles after its last strobe
    for (int k = 0; k < 40; k++) push_exp(r + 235 + 50 * k, "ch1_healthy", S_FAULT, 'h2, 0);
    push_exp(r + 2262, "ch1_to_pre",   S_FAULT, 'h2, 0);
    push_exp(r + 2262, "evt_3",        S_EVT, 'hFFFF, 3);
    push_exp(r + 2263, "ch1_to",       S_FAULT, 'h2, 'h2);
    push_exp(r + 2263, "ch1_to_cause", S_CAUSE, 'hC, 'h4);
    push_exp(r + 2263, "evt_4",        S_EVT, 'hFFFF, 4);

    // Fast fault on ch2 and its clear
    push_exp(r + 672, "ch2_fast_pre",  S_FAULT, 'h4, 0);
    push_exp(r + 672, "evt_1_hold",    S_EVT, 'hFFFF, 1);
    push_exp(r + 673, "ch2_fast",      S_FAULT, 'h4, 'h4);
    push_exp(r + 673, "ch2_fast_cause", S_CAUSE, 'h30, 'h20);
    push_exp(r + 673, "evt_2",         S_EVT, 'hFFFF, 2);
    push_exp(r + 680, "ch2_latched",   S_FAULT, 'h4, 'h4);
    push_exp(r + 681, "ch2_cleared",   S_FAULT, 'h4, 0);
    push_exp(r + 681, "ch2_cause_clr", S_CAUSE, 'h30, 0);
    push_exp(r + 402, "ch3_idle_clr",  S_FAULT, 'h8, 0);

    // Priorities on ch0
    push_exp(r + 700,  "ch0_dis_pre",   S_FAULT, 1, 1);
    push_exp(r + 701,  "ch0_dis",       S_FAULT, 1, 0);
    push_exp(r + 701,  "ch0_dis_cause", S_CAUSE, 'h3, 0);
    push_exp(r + 811,  "clr_vs_to",     S_FAULT, 1, 0);
    push_exp(r + 812,  "clr_vs_to_2",   S_FAULT, 1, 0);
    push_exp(r + 911,  "strobe_vs_to",  S_FAULT, 1, 0);
    push_exp(r + 1010, "ch0_to2_pre",   S_FAULT, 1, 0);
    push_exp(r + 1011, "ch0_to2",       S_FAULT, 1, 1);
    push_exp(r + 1011, "ch0_to2_cause", S_CAUSE, 'h3, 'h1);
    push_exp(r + 1011, "evt_3_rise",    S_EVT, 'hFFFF, 3);

    // Async reset mid-fault
    push_exp(r + 2299, "pre_rst_fault", S_FAULT, 'hF, 'h3);
    push_exp(r + 2299, "pre_rst_cause", S_CAUSE, 'hFF, 'h05);
    push_exp(r + 2299, "sr_evt_pre",    S_SR_EVT, 'hFFFF, 1);
    push_exp(r + 2300, "arst_fault",    S_FAULT, 'hF, 0);
    push_exp(r + 2300, "arst_cause",    S_CAUSE, 'hFF, 0);
    push_exp(r + 2300, "arst_evt",      S_EVT, 'hFFFF, 0);
    push_exp(r + 2300, "arst_ready",    S_READY, 1, 0);
    push_exp(r + 2300, "arst_any",      S_ANY, 1, 0);
    push_exp(r + 2300, "arst_sr_evt",   S_SR_EVT, 'hFFFF, 0);

    for (int n = 1; n <= 2300; n++) begin
      step();
      if (n == 160) en = 4'b0111;
      if (n >= 210 && n <= 2160 && (n - 160) % 50 == 0) hb[1] = ~hb[1];
      if ((n >= 210 && n <= 660 && (n - 160) % 50 == 0) || n == 670) hb[2] = ~hb[2];
      if (n == 400) clr[3] = 1'b1;
      if (n == 401) clr[3] = 1'b0;
      if (n == 680) clr[2] = 1'b1;
      if (n == 681) clr[2] = 1'b0;
      if (n == 690) en[2] = 1'b0;
      if (n == 700) en[0] = 1'b0;
      if (n == 710) en[0] = 1'b1;
      if (n == 810) clr[0] = 1'b1;
      if (n == 811) clr[0] = 1'b0;
      if (n == 908) hb[0] = ~hb[0];
      if (n == 2300) iRst_n = 1'b0;
    end

    repeat (3) step();
    en = 4'b0111;
    iRst_n = 1'b1;
    r2 = cyc;

    // Re-blanking, simultaneous faults, self-recover instance
    push_exp(r2 + 49,  "ready2_pre",   S_READY, 1, 0);
    push_exp(r2 + 50,  "ready2_rise",  S_READY, 1, 1);
    push_exp(r2 + 150, "multi_pre",    S_FAULT, 'hF, 0);
    push_exp(r2 + 151, "multi_fault",  S_FAULT, 'hF, 'h7);
    push_exp(r2 + 151, "multi_cause",  S_CAUSE, 'hFF, 'h15);
    push_exp(r2 + 151, "multi_evt",    S_EVT, 'hFFFF, 1);
    push_exp(r2 + 152, "multi_evt_2",  S_EVT, 'hFFFF, 1);
    push_exp(r2 + 151, "sr_to",        S_SR_FAULT, 'hF, 'h8);
    push_exp(r2 + 151, "sr_to_cause",  S_SR_CAUSE, 'hFF, 'h40);
    push_exp(r2 + 151, "sr_evt_1",     S_SR_EVT, 'hFFFF, 1);
    push_exp(r2 + 202, "sr_rec_pre",   S_SR_FAULT, 'h8, 'h8);
    push_exp(r2 + 203, "sr_recover",   S_SR_FAULT, 'h8, 0);
    push_exp(r2 + 203, "sr_rec_cause", S_SR_CAUSE, 'hFF, 0);
    push_exp(r2 + 400, "sr_healthy",   S_SR_FAULT, 'h8, 0);
    push_exp(r2 + 550, "sr_healthy_2", S_SR_FAULT, 'h8, 0);
    push_exp(r2 + 550, "sr_evt_once",  S_SR_EVT, 'hFFFF, 1);
    push_exp(r2 + 603, "sr_to_again",  S_SR_FAULT, 'h8, 'h8);
    push_exp(r2 + 603, "sr_evt_2",     S_SR_EVT, 'hFFFF, 2);

    for (int n = 1; n <= 620; n++) begin
      step();
      if (n >= 200 && n <= 500 && n % 50 == 0) hb_sr[3] = ~hb_sr[3];
    end

    // Bounded drain: anything still queued was never compared.
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    foreach (sb[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s never compared (due cycle %0d, expected 'h%0h)", sb[i].name, sb[i].at, sb[i].exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
